femto_seq: RTL and testbench
============================

# femto_seq

Program sequencer for the Femto 8-bit accumulator ALU (`alu_gen`). It holds a small instruction memory that the host loads over a write port. On `start` it issues one instruction per clock to the ALU's `op`/`inp` inputs and captures ALU results into a display register. When not running, it keeps the ALU in a non-accumulating state, so `acc` is preserved between runs.

## Interface
Parameters:
- `OPSIZE`, 3, ALU opcode width; must match `alu_gen`.
- `SIZE`, 8, data width; must match `alu_gen`.
- `DEPTH`, 8, number of program entries; must be a power of two.
- `AW`, 3, address width; equals log2(`DEPTH`).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `wr_en` input 1: program write strobe.
- `wr_addr` input `AW`: program write address.
- `wr_data` input `OPSIZE+SIZE`: instruction word; `{op, data}`, with `op` in the MSBs.
- `start` input 1: begin execution; sampled in IDLE only.
- `loop` input 1: sampled with `start`; 1 = wrap at end of program.
- `stop` input 1: abort a running program.
- `last_addr` input `AW`: final program entry; sampled with `start`.
- `alu_op` output `OPSIZE`: drives `alu_gen.op`.
- `alu_inp` output `SIZE`: drives `alu_gen.inp`.
- `alu_outp` input `SIZE`: from `alu_gen.outp`.
- `disp` output `SIZE`: display register.
- `disp_valid` output 1: one-cycle pulse when `disp` has just been updated.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse in DONE.
- `pc` output `AW`: address of the instruction currently issued.

## Operation
States are IDLE, RUN and DONE. Each is encoded explicitly; there is no illegal state, and any unused encoding goes to IDLE.

- **IDLE**
  - Drives `alu_op`=0 and `alu_inp`=0. Opcode 0 with `inp[3:2]`≠01 does not write `acc`.
  - On `start`: latch `loop` and `last_addr`, set `pc`=0, go to RUN.
- **RUN**
  - Drives `alu_op` = `mem[pc][OPSIZE+SIZE-1:SIZE]` and `alu_inp` = `mem[pc][SIZE-1:0]` combinationally.
  - One instruction completes per clock; the ALU updates `acc` at the same edge.
  - Next-state priority:
    - `stop`=1: go to IDLE. The instruction issued this cycle completes, and `done` does not pulse.
    - `pc`==`last_addr` and latched `loop`=0: go to DONE.
    - `pc`==`last_addr` and latched `loop`=1: set `pc`=0 and stay in RUN.
    - Otherwise: `pc`=`pc`+1, wrapping modulo `DEPTH`.
- **DONE**
  - ALU driven as in IDLE.
  - `done`=1 for exactly one cycle, then go to IDLE.
- **Display capture**
  - In a RUN cycle issuing opcode 6 (STORE ACC, `outp`=`acc`) or opcode 7 (DISPLAY, `outp`=`inp`), `disp` <= `alu_outp` at the end of that cycle.
  - `disp_valid`=1 during the following cycle only.
  - `disp` holds its value otherwise, including across runs.
- **Program memory**
  - `DEPTH` × (`OPSIZE+SIZE`) registers, not reset.
  - A write is accepted only when state is IDLE; writes in RUN or DONE are ignored.
  - `wr_en` and `start` in the same IDLE cycle: the write is committed at that edge, so it is visible to the first RUN cycle.
- **Ignored inputs**
  - `start` in RUN or DONE is ignored.
  - `stop` outside RUN is ignored.
- **Reset**
  - From any state, `rst` forces IDLE at the next edge.
  - `alu_gen.acc` is not reset by this block. Programs initialise it with opcode 1 or opcode 0/`inp[3:2]`=01.

## Timing
- Reset values: state=IDLE, `pc`=0, `disp`=0, `disp_valid`=0, `done`=0, `busy`=0, `alu_op`=0, `alu_inp`=0.
- `start` sampled at edge E: RUN from E+1 with `pc`=0 issued in cycle E+1. Instruction k is issued in cycle E+1+k.
- Non-loop run of L+1 instructions (`last_addr`=L):
  - `busy` high for cycles E+1..E+1+L.
  - `done` high in cycle E+2+L.
  - IDLE from E+3+L; the earliest next accepted `start` is sampled in cycle E+3+L.
- `disp` updates at the end of the capturing instruction's cycle; `disp_valid` is high in the next cycle.
- Back-to-back captures (6 then 7) give `disp_valid` high for two consecutive cycles.
- `alu_op`/`alu_inp` depend combinationally on state, `pc` and memory only, not on any input.

## Test plan
- **Basic run**: load [0]=`{1,05}`, [1]=`{2,03}`, [2]=`{6,00}`, [3]=`{7,AA}`; `last_addr`=3, `loop`=0, `start` -> `disp`=08 with `disp_valid`, then `disp`=AA with `disp_valid` the next cycle; `done` pulses once, 5 cycles after `start`; ALU `acc`=08 at the end.
- **Idle preservation**: after the basic run, hold IDLE for 20 cycles, then run `{6,00}` with `last_addr`=0 -> `disp`=08, showing `acc` was untouched by idle drive.
- **Loop and stop**: load [0]=`{2,01}`, [1]=`{6,00}`; `last_addr`=1, `loop`=1, `acc` pre-set to 00 -> `disp` sequence 01, 02, 03…, with `pc` alternating 0,1; assert `stop` while `pc`=1 -> one final capture, IDLE next cycle, no `done`.
- **Ignored inputs**: during RUN, pulse `start` and write [0]=`{3,FF}` -> program and result unchanged. After IDLE, re-run -> the old [0] still executes.
- **Reset mid-run**: assert `rst` in cycle E+2 of the basic run -> next cycle all outputs at reset values (`disp`=0, `busy`=0); a subsequent `start` restarts from `pc`=0.
- **Same-cycle write and start**: in IDLE, `wr_en` with [0]=`{7,5A}`, `start`, and `last_addr`=0 on the same cycle -> `disp`=5A, then `done`.

Source files
------------

// File: rtl/femto_seq_if.sv
// Host and ALU-side signal bundle for the femto_seq program sequencer.
// The slave modport is the sequencer's view; the master modport is the host/ALU environment.
interface femto_seq_if #(
  parameter int OPSIZE = 3,
  parameter int SIZE   = 8,
  parameter int AW     = 3
);
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [OPSIZE+SIZE-1:0] wr_data;
  logic                   start;
  logic                   loop;
  logic                   stop;
  logic [AW-1:0]          last_addr;
  logic [OPSIZE-1:0]      alu_op;
  logic [SIZE-1:0]        alu_inp;
  logic [SIZE-1:0]        alu_outp;
  logic [SIZE-1:0]        disp;
  logic                   disp_valid;
  logic                   busy;
  logic                   done;
  logic [AW-1:0]          pc;

  modport slave (
    input  wr_en, wr_addr, wr_data, start, loop, stop, last_addr, alu_outp,
    output alu_op, alu_inp, disp, disp_valid, busy, done, pc
  );

  modport master (
    output wr_en, wr_addr, wr_data, start, loop, stop, last_addr, alu_outp,
    input  alu_op, alu_inp, disp, disp_valid, busy, done, pc
  );
endinterface

// File: rtl/femto_seq.sv
// Program sequencer for the Femto accumulator ALU: issues one stored instruction per
// clock while running and captures STORE ACC / DISPLAY results into a display register.
module femto_seq #(
  parameter int OPSIZE = 3,
  parameter int SIZE   = 8,
  parameter int DEPTH  = 8,
  parameter int AW     = 3
) (
  input  logic        clk,
  input  logic        rst,
  femto_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [OPSIZE-1:0] OP_STORE = OPSIZE'(6);
  localparam logic [OPSIZE-1:0] OP_DISP  = OPSIZE'(7);

  state_t                 state;
  state_t                 state_next;
  logic [AW-1:0]          pc;
  logic [AW-1:0]          pc_next;
  logic [AW-1:0]          last_q;
  logic                   loop_q;
  logic [OPSIZE+SIZE-1:0] mem [DEPTH];
  logic [OPSIZE+SIZE-1:0] instr;
  logic                   capture;
  logic [SIZE-1:0]        disp;
  logic                   disp_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= '0;
      loop_q <= 1'b0;
      last_q <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (state == IDLE && bus.start) begin
        loop_q <= bus.loop;
        last_q <= bus.last_addr;
      end
    end
  end

  // Unused state encodings fall through to IDLE via the default branch.
  always_comb begin
    state_next = IDLE;
    pc_next    = pc;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          pc_next    = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_next = IDLE;
        end else if (pc == last_q) begin
          if (loop_q) begin
            state_next = RUN;
            pc_next    = '0;
          end else begin
            state_next = DONE;
          end
        end else begin
          state_next = RUN;
          pc_next    = pc + AW'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Memory is writable only while idle, including the cycle that samples start.
  always_ff @(posedge clk) begin
    if (bus.wr_en && state == IDLE) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign instr   = mem[pc];
  assign capture = (state == RUN) &&
                   (instr[OPSIZE+SIZE-1:SIZE] == OP_STORE || instr[OPSIZE+SIZE-1:SIZE] == OP_DISP);

  always_ff @(posedge clk) begin
    if (rst) begin
      disp       <= '0;
      disp_valid <= 1'b0;
    end else begin
      disp_valid <= capture;
      if (capture) begin
        disp <= bus.alu_outp;
      end
    end
  end

  // Outside RUN the ALU sees opcode 0 / inp 0, which leaves acc untouched.
  assign bus.alu_op     = (state == RUN) ? instr[OPSIZE+SIZE-1:SIZE] : '0;
  assign bus.alu_inp    = (state == RUN) ? instr[SIZE-1:0] : '0;
  assign bus.disp       = disp;
  assign bus.disp_valid = disp_valid;
  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.pc         = pc;

endmodule

// File: tb/tb_femto_seq.sv
// Directed self-checking bench for femto_seq with a small behavioural accumulator ALU.
module tb_femto_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] acc;

  always #5 clk = ~clk;

  femto_seq_if #(.OPSIZE(3), .SIZE(8), .AW(3)) bus ();

  femto_seq #(.OPSIZE(3), .SIZE(8), .DEPTH(8), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in ALU: 1 load, 2 add, 3 xor, 0 with inp[3:2]=01 clears; 7 passes inp, else outp=acc.
  always_ff @(posedge clk) begin
    case (bus.alu_op)
      3'd0: if (bus.alu_inp[3:2] == 2'b01) acc <= 8'h00;
      3'd1: acc <= bus.alu_inp;
      3'd2: acc <= acc + bus.alu_inp;
      3'd3: acc <= acc ^ bus.alu_inp;
      default: ;
    endcase
  end
  assign bus.alu_outp = (bus.alu_op == 3'd7) ? bus.alu_inp : acc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic writeInstr(input logic [2:0] addr, input logic [2:0] op, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = {op, data};
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic applyStimulus(input logic st, input logic lp, input logic [2:0] last, input logic sp);
    bus.start     = st;
    bus.loop      = lp;
    bus.last_addr = last;
    bus.stop      = sp;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    tick();
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_done", bus.done, 1'b0);
    checkOutput("rst_disp", bus.disp, 8'h00);
    checkOutput("rst_valid", bus.disp_valid, 1'b0);
    checkOutput("rst_pc", bus.pc, 3'd0);
    checkOutput("rst_op", bus.alu_op, 3'd0);
    checkOutput("rst_inp", bus.alu_inp, 8'h00);
    rst = 1'b0;
    tick();

    $display("[TB] basic run");
    writeInstr(3'd0, 3'd1, 8'h05);
    writeInstr(3'd1, 3'd2, 8'h03);
    writeInstr(3'd2, 3'd6, 8'h00);
    writeInstr(3'd3, 3'd7, 8'hAA);
    applyStimulus(1'b1, 1'b0, 3'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("basic_busy0", bus.busy, 1'b1);
    checkOutput("basic_pc0", bus.pc, 3'd0);
    checkOutput("basic_op0", {bus.alu_op, bus.alu_inp}, {3'd1, 8'h05});
    tick();
    checkOutput("basic_pc1", bus.pc, 3'd1);
    tick();
    checkOutput("basic_op2", bus.alu_op, 3'd6);
    checkOutput("basic_valid_early", bus.disp_valid, 1'b0);
    tick();
    checkOutput("basic_disp08", bus.disp, 8'h08);
    checkOutput("basic_valid1", bus.disp_valid, 1'b1);
    checkOutput("basic_done_early", bus.done, 1'b0);
    tick();
    checkOutput("basic_dispAA", bus.disp, 8'hAA);
    checkOutput("basic_valid2", bus.disp_valid, 1'b1);
    checkOutput("basic_done", bus.done, 1'b1);
    checkOutput("basic_busy_done", bus.busy, 1'b0);
    checkOutput("basic_idle_op", bus.alu_op, 3'd0);
    tick();
    checkOutput("basic_done_once", bus.done, 1'b0);
    checkOutput("basic_valid_off", bus.disp_valid, 1'b0);
    checkOutput("basic_acc", acc, 8'h08);
    checkOutput("basic_disp_hold", bus.disp, 8'hAA);

    $display("[TB] idle preservation");
    for (int i = 0; i < 20; i++) tick();
    writeInstr(3'd0, 3'd6, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("idle_busy", bus.busy, 1'b1);
    tick();
    checkOutput("idle_disp", bus.disp, 8'h08);
    checkOutput("idle_valid", bus.disp_valid, 1'b1);
    checkOutput("idle_done", bus.done, 1'b1);
    tick();

    $display("[TB] loop and stop");
    writeInstr(3'd0, 3'd1, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    tick();
    checkOutput("loop_acc_clear", acc, 8'h00);
    writeInstr(3'd0, 3'd2, 8'h01);
    writeInstr(3'd1, 3'd6, 8'h00);
    applyStimulus(1'b1, 1'b1, 3'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("loop_pc_a", bus.pc, 3'd0);
    tick();
    checkOutput("loop_pc_b", bus.pc, 3'd1);
    tick();
    checkOutput("loop_disp01", bus.disp, 8'h01);
    checkOutput("loop_valid01", bus.disp_valid, 1'b1);
    checkOutput("loop_wrap_pc", bus.pc, 3'd0);
    checkOutput("loop_busy", bus.busy, 1'b1);
    tick();
    checkOutput("loop_pc_c", bus.pc, 3'd1);
    checkOutput("loop_valid_gap", bus.disp_valid, 1'b0);
    tick();
    checkOutput("loop_disp02", bus.disp, 8'h02);
    tick();
    checkOutput("loop_stop_pc", bus.pc, 3'd1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    checkOutput("stop_disp03", bus.disp, 8'h03);
    checkOutput("stop_valid", bus.disp_valid, 1'b1);
    checkOutput("stop_busy", bus.busy, 1'b0);
    checkOutput("stop_no_done", bus.done, 1'b0);
    tick();
    checkOutput("stop_no_done2", bus.done, 1'b0);
    checkOutput("stop_idle_op", bus.alu_op, 3'd0);

    $display("[TB] ignored inputs");
    applyStimulus(1'b1, 1'b0, 3'd1, 1'b0);
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_data = {3'd3, 8'hFF};
    tick();
    bus.wr_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("ign_pc", bus.pc, 3'd1);
    checkOutput("ign_op", bus.alu_op, 3'd6);
    tick();
    checkOutput("ign_disp04", bus.disp, 8'h04);
    checkOutput("ign_done", bus.done, 1'b1);
    tick();
    checkOutput("ign_idle", bus.busy, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("ign_old_instr", {bus.alu_op, bus.alu_inp}, {3'd2, 8'h01});
    tick();
    tick();
    checkOutput("ign_disp05", bus.disp, 8'h05);
    tick();

    $display("[TB] reset mid-run");
    writeInstr(3'd0, 3'd1, 8'h05);
    writeInstr(3'd1, 3'd2, 8'h03);
    writeInstr(3'd2, 3'd6, 8'h00);
    writeInstr(3'd3, 3'd7, 8'hAA);
    applyStimulus(1'b1, 1'b0, 3'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mrst_busy", bus.busy, 1'b0);
    checkOutput("mrst_disp", bus.disp, 8'h00);
    checkOutput("mrst_pc", bus.pc, 3'd0);
    checkOutput("mrst_op", bus.alu_op, 3'd0);
    checkOutput("mrst_done", bus.done, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("mrst_restart_pc", bus.pc, 3'd0);
    checkOutput("mrst_restart_op", bus.alu_op, 3'd1);
    tick();
    tick();
    tick();
    checkOutput("mrst_disp08", bus.disp, 8'h08);
    tick();
    checkOutput("mrst_dispAA", bus.disp, 8'hAA);
    checkOutput("mrst_done2", bus.done, 1'b1);
    tick();

    $display("[TB] same-cycle write and start");
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'd0;
    bus.wr_data = {3'd7, 8'h5A};
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    bus.wr_en = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("same_inp", bus.alu_inp, 8'h5A);
    tick();
    checkOutput("same_disp", bus.disp, 8'h5A);
    checkOutput("same_valid", bus.disp_valid, 1'b1);
    checkOutput("same_done", bus.done, 1'b1);
    tick();
    checkOutput("same_idle", bus.done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
